pixel_fetch: RTL and testbench
==============================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_WIDTH, 41, image width in pixels.
- IMG_HEIGHT, 50, image height in pixels.
- SWEEP_X, 25, window width.
- SWEEP_Y, 25, window height.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 4, output buffer entries; legal range 3..16.
REQ-002 Derived widths: W_X = clog2(IMG_WIDTH); W_Y = clog2(IMG_HEIGHT); W_A = clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-003 One clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- addr_valid, in, 1, upstream coordinate valid.
- addr_ready, out, 1, coordinate accepted.
- x, in, W_X, pixel column.
- y, in, W_Y, pixel row.
- mem_rd_en, out, 1, image RAM read strobe.
- mem_addr, out, W_A, image RAM address.
- mem_rd_data, in, DATA_W, RAM read data, valid 1 cycle after mem_rd_en.
- pix_valid, out, 1, pixel available.
- pix_ready, in, 1, downstream accepts pixel.
- pix_data, out, DATA_W, pixel value.
- pix_last, out, 1, final pixel of a SWEEP_X*SWEEP_Y window.
- oob_err, out, 1, sticky out-of-bounds coordinate flag.

Function
REQ-005 Accept: an address handshake occurs in any cycle where addr_valid and addr_ready are both 1.
REQ-006 Read issue: mem_rd_en = addr_valid & addr_ready, driven combinationally with no registering.
REQ-007 Address: mem_addr = y*IMG_WIDTH + x, computed at full W_A width with no truncation of the product.
REQ-008 Out-of-bounds coordinates (x >= IMG_WIDTH or y >= IMG_HEIGHT) are handled as follows.
- mem_addr = 0 and mem_rd_en = 0.
- The entry still occupies a slot and produces a pixel of value 0.
- oob_err is set the next cycle and held until rst.
REQ-009 Memory latency is fixed at 1 cycle. Data returned for a read issued in cycle T is written into the FIFO at the end of cycle T+1.
REQ-010 In-flight flag: a 1-bit inflight register is set on each accept and cleared otherwise. It tags the FIFO write in the following cycle with the captured data (or 0 for OOB), plus a last bit.
REQ-011 Credit rule: addr_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state only (no combinational path from pix_ready).
REQ-012 Overflow is impossible by REQ-011. A FIFO write while full is a design error; the bench asserts it never occurs.
REQ-013 FIFO behaviour:
- First-word-fall-through: pix_valid = (fifo_count != 0); pix_data and pix_last come from the head entry.
- Pop on pix_valid & pix_ready.
- Simultaneous push and pop leaves count unchanged.
- Pop while empty has no effect.
REQ-014 Minimum latency: an accept in cycle T gives pix_valid in cycle T+2 when the FIFO was empty.
REQ-015 Throughput: with FIFO_DEPTH >= 3 and pix_ready held at 1, sustained throughput is 1 pixel per cycle.
REQ-016 Window counter:
- Counts accepted addresses 0..SWEEP_X*SWEEP_Y-1.
- The entry accepted at count SWEEP_X*SWEEP_Y-1 is tagged last = 1.
- The counter then wraps to 0.
- OOB entries are counted.
REQ-017 Ordering: pixels leave in exactly the accept order, and every accepted address yields exactly one output pixel.
REQ-018 Back-pressure: while pix_valid = 1 and pix_ready = 0, pix_data and pix_last hold stable.

Reset
REQ-019 On rst = 1 at a clock edge:
- fifo_count, FIFO pointers, inflight, window counter and oob_err are cleared to 0.
- pix_valid = 0, pix_last = 0, pix_data = 0.
REQ-020 While rst is 1, addr_ready = 0 and mem_rd_en = 0. After reset is released, addr_ready = 1 in the first cycle.
REQ-021 Reset mid-operation discards all buffered and in-flight pixels. RAM data returning in the cycle after reset is ignored.

Verification
REQ-022 Reset check: hold rst 3 cycles, then release -> during reset addr_ready = 0 and pix_valid = 0; in the first post-reset cycle addr_ready = 1 and oob_err = 0.
REQ-023 Single read: accept (x=3, y=2), RAM model returns mem_addr+1 -> mem_addr = 85 in T; pix_valid at T+2 with pix_data = 86.
REQ-024 Streaming: 625 sequential in-bounds addresses, pix_ready = 1, FIFO_DEPTH = 4 -> 625 pixels in order, one per cycle after initial latency 2; pix_last = 1 only on pixel 625; counter wraps so pixel 1250 is last.
REQ-025 Back-pressure: pix_ready = 0 for 10 cycles while addr_valid = 1 -> exactly 4 accepts, then addr_ready = 0; no loss or duplication after pix_ready returns; pix_data stable while stalled.
REQ-026 OOB: accept (x=41, y=0), then (x=0, y=50) -> mem_rd_en = 0 for both; two pixels of value 0 output; oob_err = 1 from the next cycle until rst.
REQ-027 Mid-stream reset: assert rst with 3 pixels buffered and 1 in flight -> after release, no stale pixel appears; first new accept produces the correct pixel with window count restarted at 0.

Source files
------------

// File: rtl/pixel_fetch.sv
// Coordinate-to-pixel fetcher: turns (x, y) requests into image RAM reads and
// buffers returned pixels in a credit-controlled first-word-fall-through FIFO.
module pixel_fetch #(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int SWEEP_X    = 25,
    parameter int SWEEP_Y    = 25,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int W_X        = $clog2(IMG_WIDTH),
    parameter int W_Y        = $clog2(IMG_HEIGHT),
    parameter int W_A        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [W_X-1:0]    x,
    input  logic [W_Y-1:0]    y,
    output logic              mem_rd_en,
    output logic [W_A-1:0]    mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              oob_err
);

    localparam int WIN_LEN = SWEEP_X * SWEEP_Y;
    localparam int W_WIN   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int W_PTR   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int W_CNT   = $clog2(FIFO_DEPTH + 1);
    localparam int W_CR    = W_CNT + 1;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [W_PTR-1:0]  wr_ptr;
    logic [W_PTR-1:0]  rd_ptr;
    logic [W_CNT-1:0]  fifo_count;

    logic              inflight;
    logic              inflight_oob;
    logic              inflight_last;
    logic [W_WIN-1:0]  win_cnt;

    logic              in_bounds;
    logic              accept;
    logic              win_end;
    logic              push;
    logic              pop;
    logic [W_A-1:0]    lin_addr;
    logic [W_CR-1:0]   credit_used;

    function automatic logic [W_PTR-1:0] ptr_next(input logic [W_PTR-1:0] p);
        return (p == W_PTR'(FIFO_DEPTH - 1)) ? '0 : p + W_PTR'(1);
    endfunction

    assign in_bounds = (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
    assign lin_addr  = W_A'(y) * W_A'(IMG_WIDTH) + W_A'(x);

    // Credit counts both stored entries and the read whose data is still on the bus.
    assign credit_used = W_CR'(fifo_count) + W_CR'(inflight);
    assign addr_ready  = !rst && (int'(credit_used) < FIFO_DEPTH);
    assign accept      = addr_valid && addr_ready;

    assign mem_rd_en = accept && in_bounds;
    assign mem_addr  = in_bounds ? lin_addr : '0;

    assign win_end   = (win_cnt == W_WIN'(WIN_LEN - 1));
    assign push      = inflight;
    assign pix_valid = (fifo_count != '0);
    assign pop       = pix_valid && pix_ready;

    // Gated so stale storage never shows on the outputs when the FIFO is empty.
    assign pix_data = pix_valid ? fifo_data[rd_ptr] : '0;
    assign pix_last = pix_valid ? fifo_last[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_oob  <= 1'b0;
            inflight_last <= 1'b0;
            win_cnt       <= '0;
            oob_err       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            inflight      <= accept;
            inflight_oob  <= accept && !in_bounds;
            inflight_last <= accept && win_end;

            if (accept) begin
                win_cnt <= win_end ? '0 : win_cnt + W_WIN'(1);
            end

            if (accept && !in_bounds) begin
                oob_err <= 1'b1;
            end

            if (push) begin
                fifo_data[wr_ptr] <= inflight_oob ? '0 : mem_rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ptr_next(wr_ptr);
            end

            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + W_CNT'(1);
                2'b01:   fifo_count <= fifo_count - W_CNT'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: a negedge scoreboard predicts every
// pixel from the accepted coordinates; scenario tasks check timing and flags.
module tb_pixel_fetch;

    localparam int IW  = 41;
    localparam int IH  = 50;
    localparam int SX  = 25;
    localparam int SY  = 25;
    localparam int DW  = 8;
    localparam int FD  = 4;
    localparam int WX  = $clog2(IW);
    localparam int WY  = $clog2(IH);
    localparam int WA  = $clog2(IW * IH);
    localparam int WIN = SX * SY;

    logic          clk;
    logic          rst;
    logic          addr_valid;
    logic          addr_ready;
    logic [WX-1:0] x;
    logic [WY-1:0] y;
    logic          mem_rd_en;
    logic [WA-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          pix_last;
    logic          oob_err;

    pixel_fetch #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .SWEEP_X   (SX),
        .SWEEP_Y   (SY),
        .DATA_W    (DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .x          (x),
        .y          (y),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .oob_err    (oob_err)
    );

    always #5 clk = ~clk;

    // RAM model: data = address + 1, junk when no read was issued.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? 8'(mem_addr + 12'd1) : 8'hA5;
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wcnt_m = 0;
    int   outstanding = 0;
    int   overflow_seen = 0;
    int   pop_cnt = 0;
    int   acc_cnt = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    int   first_acc_cyc = 0;
    int   last_idx_q[$];

    function automatic logic [DW-1:0] exp_pix(input logic [WX-1:0] cx, input logic [WY-1:0] cy);
        if (int'(cx) >= IW || int'(cy) >= IH) return '0;
        return 8'(int'(cy) * IW + int'(cx) + 1);
    endfunction

    // Scoreboard: pop/compare first, then record a new accept.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            wcnt_m = 0;
            outstanding = 0;
        end else begin
            if (pix_valid && pix_ready) begin
                n_run++;
                pop_cnt++;
                if (pop_cnt == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (pix_last) last_idx_q.push_back(pop_cnt);
                outstanding--;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra_pixel: got data=%0h last=%0b, required no pixel", pix_data, pix_last);
                end else begin
                    e = exp_q.pop_front();
                    if (pix_data !== e.data || pix_last !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_pixel #%0d: got data=%0h last=%0b, required data=%0h last=%0b",
                                 pop_cnt, pix_data, pix_last, e.data, e.last);
                    end
                end
            end
            if (addr_valid && addr_ready) begin
                acc_cnt++;
                if (acc_cnt == 1) first_acc_cyc = cyc;
                exp_q.push_back('{data: exp_pix(x, y), last: (wcnt_m == WIN - 1)});
                wcnt_m = (wcnt_m == WIN - 1) ? 0 : wcnt_m + 1;
                outstanding++;
                if (outstanding > FD) overflow_seen++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int a);
        x = WX'(a % IW);
        y = WY'(a / IW);
    endtask

    task automatic clear_stats();
        pop_cnt = 0;
        acc_cnt = 0;
        last_idx_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        addr_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!pix_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic stream(input int n, input int base, output int stalls);
        bit ok;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            set_addr(base + i);
            addr_valid = 1'b1;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                ok = addr_ready;
                tick();
                if (ok) break;
                stalls++;
            end
        end
        addr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr_valid = 1'b1;
        x = 3;
        y = 2;
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_run++;
            if (addr_ready !== 1'b0 || mem_rd_en !== 1'b0 || pix_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got ready=%0b rd_en=%0b pix_valid=%0b, required 0 0 0",
                         addr_ready, mem_rd_en, pix_valid);
            end
        end
        tick();
        rst = 1'b0;
        addr_valid = 1'b0;
        @(negedge clk);
        n_run++;
        if (addr_ready !== 1'b1 || oob_err !== 1'b0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%0b oob=%0b pix_valid=%0b, required 1 0 0",
                     addr_ready, oob_err, pix_valid);
        end
        tick();
    endtask

    task automatic test_single_read();
        bit ok;
        clear_stats();
        pix_ready = 1'b0;
        x = 3;
        y = 2;
        addr_valid = 1'b1;
        @(negedge clk);
        n_run++;
        if (addr_ready !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 12'd85) begin
            n_fail++;
            $display("FAIL single_issue: got ready=%0b rd_en=%0b addr=%0d, required 1 1 85",
                     addr_ready, mem_rd_en, mem_addr);
        end
        tick();
        addr_valid = 1'b0;
        @(negedge clk);
        n_run++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: got pix_valid=%0b, required 0", pix_valid);
        end
        tick();
        @(negedge clk);
        n_run++;
        if (pix_valid !== 1'b1 || pix_data !== 8'd86) begin
            n_fail++;
            $display("FAIL single_t2: got pix_valid=%0b data=%0d, required 1 86", pix_valid, pix_data);
        end
        tick();
        pix_ready = 1'b1;
        drain(10, ok);
        n_run++;
        if (!ok || pop_cnt != 1) begin
            n_fail++;
            $display("FAIL single_drain: got drained=%0b pops=%0d, required 1 1", ok, pop_cnt);
        end
    endtask

    task automatic test_back_pressure();
        bit ok, acc, have;
        int ix, n_acc;
        logic [DW-1:0] hd;
        logic hl;
        clear_stats();
        pix_ready = 1'b0;
        ix = 0;
        n_acc = 0;
        have = 1'b0;
        hd = '0;
        hl = 1'b0;
        set_addr(200);
        addr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = addr_ready;
            if (pix_valid) begin
                if (have) begin
                    n_run++;
                    if (pix_data !== hd || pix_last !== hl) begin
                        n_fail++;
                        $display("FAIL bp_stable: got data=%0h last=%0b, required data=%0h last=%0b",
                                 pix_data, pix_last, hd, hl);
                    end
                end else begin
                    have = 1'b1;
                    hd = pix_data;
                    hl = pix_last;
                end
            end
            tick();
            if (acc) begin
                n_acc++;
                ix++;
                set_addr(200 + ix);
            end
        end
        @(negedge clk);
        n_run++;
        if (n_acc != FD || addr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepts: got accepts=%0d ready=%0b, required %0d 0", n_acc, addr_ready, FD);
        end
        tick();
        addr_valid = 1'b0;
        pix_ready = 1'b1;
        drain(30, ok);
        n_run++;
        if (!ok || pop_cnt != FD) begin
            n_fail++;
            $display("FAIL bp_drain: got drained=%0b pops=%0d, required 1 %0d", ok, pop_cnt, FD);
        end
    endtask

    task automatic test_oob();
        bit ok;
        clear_stats();
        pix_ready = 1'b1;
        x = 41;
        y = 0;
        addr_valid = 1'b1;
        @(negedge clk);
        n_run++;
        if (addr_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== '0 || oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_x: got ready=%0b rd_en=%0b addr=%0d oob=%0b, required 1 0 0 0",
                     addr_ready, mem_rd_en, mem_addr, oob_err);
        end
        tick();
        x = 0;
        y = 50;
        @(negedge clk);
        n_run++;
        if (addr_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== '0 || oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_y: got ready=%0b rd_en=%0b addr=%0d oob=%0b, required 1 0 0 1",
                     addr_ready, mem_rd_en, mem_addr, oob_err);
        end
        tick();
        addr_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_run++;
            if (oob_err !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_sticky: got oob=%0b, required 1", oob_err);
            end
            tick();
        end
        drain(10, ok);
        n_run++;
        if (!ok || pop_cnt != 2) begin
            n_fail++;
            $display("FAIL oob_drain: got drained=%0b pops=%0d, required 1 2", ok, pop_cnt);
        end
        do_reset(2);
        @(negedge clk);
        n_run++;
        if (oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_clear: got oob=%0b, required 0", oob_err);
        end
        tick();
    endtask

    task automatic test_midstream_reset();
        bit ok;
        int stalls;
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_addr(300 + i);
            addr_valid = 1'b1;
            @(negedge clk);
            n_run++;
            if (addr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_fill %0d: got ready=%0b, required 1", i, addr_ready);
            end
            tick();
        end
        addr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if (pix_valid !== 1'b1 || addr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_state: got pix_valid=%0b ready=%0b, required 1 0", pix_valid, addr_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        pix_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_run++;
            if (pix_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale: got pix_valid=%0b data=%0h, required pix_valid 0", pix_valid, pix_data);
            end
            tick();
        end
        clear_stats();
        stream(WIN, 500, stalls);
        drain(20, ok);
        n_run++;
        if (!ok || pop_cnt != WIN || last_idx_q.size() != 1 || (last_idx_q.size() == 1 && last_idx_q[0] != WIN)) begin
            n_fail++;
            $display("FAIL mid_restart: got drained=%0b pops=%0d lasts=%0d, required 1 %0d 1 at %0d",
                     ok, pop_cnt, last_idx_q.size(), WIN, WIN);
        end
    endtask

    task automatic test_streaming();
        bit ok;
        int stalls;
        do_reset(2);
        pix_ready = 1'b1;
        clear_stats();
        stream(2 * WIN, 0, stalls);
        drain(20, ok);
        n_run++;
        if (!ok || stalls != 0 || pop_cnt != 2 * WIN) begin
            n_fail++;
            $display("FAIL stream_count: got drained=%0b stalls=%0d pops=%0d, required 1 0 %0d",
                     ok, stalls, pop_cnt, 2 * WIN);
        end
        n_run++;
        if (last_idx_q.size() != 2 || (last_idx_q.size() == 2 && (last_idx_q[0] != WIN || last_idx_q[1] != 2 * WIN))) begin
            n_fail++;
            $display("FAIL stream_last: got %0d last pixels, required 2 at %0d and %0d",
                     last_idx_q.size(), WIN, 2 * WIN);
        end
        n_run++;
        if (first_pop_cyc - first_acc_cyc != 2 || last_pop_cyc - first_pop_cyc != 2 * WIN - 1) begin
            n_fail++;
            $display("FAIL stream_rate: got latency=%0d span=%0d, required 2 %0d",
                     first_pop_cyc - first_acc_cyc, last_pop_cyc - first_pop_cyc, 2 * WIN - 1);
        end
    endtask

    task automatic test_no_overflow();
        n_run++;
        if (overflow_seen != 0) begin
            n_fail++;
            $display("FAIL overflow: got %0d cycles above %0d outstanding, required 0", overflow_seen, FD);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        addr_valid = 1'b0;
        x = '0;
        y = '0;
        pix_ready = 1'b0;
        test_reset();
        test_single_read();
        test_back_pressure();
        test_oob();
        test_midstream_reset();
        test_streaming();
        test_no_overflow();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
